// File: rtl/pcmc_pkg.sv
// Shared encodings for the multicycle PC / memory / control front end:
// FSM state codes, opcodes and the datapath select encodings.
package pcmc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_RTYPE1 = 4'd2,
        S_RTYPE2 = 4'd3,
        S_SW     = 4'd4,
        S_LW1    = 4'd5,
        S_LW2    = 4'd6,
        S_J      = 4'd7,
        S_LI     = 4'd8,
        S_MOV    = 4'd9,
        S_BEQ1   = 4'd10,
        S_BEQ2   = 4'd11,
        S_JAL    = 4'd12,
        S_PUSH   = 4'd13,
        S_POP1   = 4'd14,
        S_POP2   = 4'd15
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_SW    = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_J     = 4'h3;
    localparam logic [3:0] OP_LI    = 4'h4;
    localparam logic [3:0] OP_MOV   = 4'h5;
    localparam logic [3:0] OP_BEQ   = 4'h6;
    localparam logic [3:0] OP_JAL   = 4'h7;
    localparam logic [3:0] OP_PUSH  = 4'h8;
    localparam logic [3:0] OP_POP   = 4'h9;

    localparam logic [1:0] PCSRC_JMP  = 2'b00;  // {PC[15:12], tgt}
    localparam logic [1:0] PCSRC_INC  = 2'b01;  // PC + 1
    localparam logic [1:0] PCSRC_REL  = 2'b10;  // PC + sext(imm8)
    localparam logic [1:0] PCSRC_HOLD = 2'b11;  // PC

    localparam logic [1:0] MADDR_IMM  = 2'b00;
    localparam logic [1:0] MADDR_PC   = 2'b01;
    localparam logic [1:0] MADDR_SP   = 2'b10;
    localparam logic [1:0] MADDR_IMM2 = 2'b11;

    localparam logic [2:0] RFWD_MDR = 3'b000;
    localparam logic [2:0] RFWD_PC  = 3'b001;
    localparam logic [2:0] RFWD_REG = 3'b010;
    localparam logic [2:0] RFWD_ALU = 3'b011;
    localparam logic [2:0] RFWD_IMM = 3'b100;

    localparam logic [1:0] RFWA_RD   = 2'b00;
    localparam logic [1:0] RFWA_LINK = 2'b01;
    localparam logic [1:0] RFWA_IMM  = 2'b10;

    localparam logic [3:0] ALUOP_CMP = 4'd5;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/pcmc_ctrl_fsm.sv
// 16-state Moore control FSM: state register, opcode dispatch from DECODE,
// and per-state decode of every datapath control line.
module pcmc_ctrl_fsm
    import pcmc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] op,
    input  logic [3:0] funct,
    output logic [3:0] crt_state,
    output logic       pcwrite,
    output logic       mdin,
    output logic       mread,
    output logic       mwrite,
    output logic       rfread,
    output logic       rdwrite,
    output logic       spwrite,
    output logic       awrite,
    output logic       bwrite,
    output logic       aluina,
    output logic       aluoutwrite,
    output logic       branch,
    output logic       sprel,
    output logic       pshpop,
    output logic [1:0] pcsrc,
    output logic [1:0] maddr,
    output logic [1:0] rfwa,
    output logic [1:0] aluinb,
    output logic [2:0] rfwd,
    output logic [3:0] aluop
);

    state_t state, nxt;

    assign crt_state = state;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= nxt;
    end

    // Next state and Moore outputs, everything defaults low
    always_comb begin
        nxt         = S_FETCH;
        pcwrite     = 1'b0;
        mdin        = 1'b0;
        mread       = 1'b0;
        mwrite      = 1'b0;
        rfread      = 1'b0;
        rdwrite     = 1'b0;
        spwrite     = 1'b0;
        awrite      = 1'b0;
        bwrite      = 1'b0;
        aluina      = 1'b0;
        aluoutwrite = 1'b0;
        branch      = 1'b0;
        sprel       = 1'b0;
        pshpop      = 1'b0;
        pcsrc       = PCSRC_JMP;
        maddr       = MADDR_IMM;
        rfwa        = RFWA_RD;
        aluinb      = 2'b00;
        rfwd        = RFWD_MDR;
        aluop       = 4'd0;
        case (state)
            S_FETCH: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_INC;
                maddr   = MADDR_PC;
                mread   = 1'b1;
                nxt     = S_DECODE;
            end
            S_DECODE: begin
                rfread = 1'b1;
                awrite = 1'b1;
                bwrite = 1'b1;
                case (op)
                    OP_RTYPE: nxt = S_RTYPE1;
                    OP_SW:    nxt = S_SW;
                    OP_LW:    nxt = S_LW1;
                    OP_J:     nxt = S_J;
                    OP_LI:    nxt = S_LI;
                    OP_MOV:   nxt = S_MOV;
                    OP_BEQ:   nxt = S_BEQ1;
                    OP_JAL:   nxt = S_JAL;
                    OP_PUSH:  nxt = S_PUSH;
                    OP_POP:   nxt = S_POP1;
                    default:  nxt = S_FETCH;
                endcase
            end
            S_RTYPE1: begin
                aluina      = 1'b1;
                aluoutwrite = 1'b1;
                aluop       = funct;
                nxt         = S_RTYPE2;
            end
            S_RTYPE2: begin
                rfwd    = RFWD_ALU;
                rdwrite = 1'b1;
            end
            S_SW: begin
                mdin   = 1'b1;
                maddr  = MADDR_IMM2;
                mwrite = 1'b1;
            end
            S_LW1: begin
                mread = 1'b1;
                nxt   = S_LW2;
            end
            S_LW2:  rdwrite = 1'b1;
            S_J:    pcwrite = 1'b1;
            S_LI: begin
                rfwa    = RFWA_IMM;
                rfwd    = RFWD_IMM;
                rdwrite = 1'b1;
            end
            S_MOV: begin
                rfwd    = RFWD_REG;
                rdwrite = 1'b1;
            end
            S_BEQ1: begin
                aluop  = ALUOP_CMP;
                aluina = 1'b1;
                nxt    = S_BEQ2;
            end
            // PC only moves here if the comparison flag is set
            S_BEQ2: begin
                pcsrc  = PCSRC_REL;
                branch = 1'b1;
            end
            S_JAL: begin
                rfwd    = RFWD_PC;
                rfwa    = RFWA_LINK;
                rdwrite = 1'b1;
                pcwrite = 1'b1;
            end
            S_PUSH: begin
                maddr   = MADDR_SP;
                spwrite = 1'b1;
                mdin    = 1'b1;
                mwrite  = 1'b1;
            end
            S_POP1: begin
                pshpop  = 1'b1;
                maddr   = MADDR_PC;
                spwrite = 1'b1;
                mread   = 1'b1;
                nxt     = S_POP2;
            end
            S_POP2: rdwrite = 1'b1;
            default: nxt = S_FETCH;
        endcase
    end

endmodule

// File: rtl/test_pc_mem_control.sv
// Multicycle CPU front end: PC, SP, IR, MDR, word memory and the control FSM.
// Build option PCMC_D2A_COMB_EN: d2a shows the combinational memory read
// data instead of the registered MDR.
module test_pc_mem_control
    import pcmc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Comparison,
    output logic        PCWrite,
    output logic        MDin,
    output logic        MRead,
    output logic        MWrite,
    output logic        RFRead,
    output logic        RDWrite,
    output logic        SPWrite,
    output logic        AWrite,
    output logic        BWrite,
    output logic        ALUInA,
    output logic        ALUOutWrite,
    output logic        Branch,
    output logic        SPRel,
    output logic        PshPop,
    output logic [1:0]  PCSrc,
    output logic [1:0]  MAddr,
    output logic [1:0]  RFWA,
    output logic [1:0]  ALUInB,
    output logic [2:0]  RFWD,
    output logic [3:0]  ALUOp,
    output logic [15:0] d2a,
    output logic [15:0] PC,
    output logic [3:0]  CrtState
);

    localparam int WORDS = 2 ** ADDR_W;

    logic [15:0] ir, mdr, sp, pc_next, rdata;
    logic [ADDR_W-1:0] addr;
    logic pc_load;

    // Boot image lives in the array itself so reset never clears memory
    logic [15:0] mem [WORDS] = '{
        0: 16'h0003, 1: 16'h1080, 2: 16'h2080, 3: 16'h3004, 4: 16'h4012,
        5: 16'h5000, 6: 16'h6002, 7: 16'h7009, 8: 16'h0000, 9: 16'h8000,
        10: 16'h9000, default: 16'h0000
    };

    pcmc_ctrl_fsm u_fsm (
        .clk         (CLK),
        .rst         (RST),
        .op          (ir[15:12]),
        .funct       (ir[3:0]),
        .crt_state   (CrtState),
        .pcwrite     (PCWrite),
        .mdin        (MDin),
        .mread       (MRead),
        .mwrite      (MWrite),
        .rfread      (RFRead),
        .rdwrite     (RDWrite),
        .spwrite     (SPWrite),
        .awrite      (AWrite),
        .bwrite      (BWrite),
        .aluina      (ALUInA),
        .aluoutwrite (ALUOutWrite),
        .branch      (Branch),
        .sprel       (SPRel),
        .pshpop      (PshPop),
        .pcsrc       (PCSrc),
        .maddr       (MAddr),
        .rfwa        (RFWA),
        .aluinb      (ALUInB),
        .rfwd        (RFWD),
        .aluop       (ALUOp)
    );

    // Memory address select; imm8 is zero-extended
    always_comb begin
        case (MAddr)
            MADDR_PC: addr = PC[ADDR_W-1:0];
            MADDR_SP: addr = sp[ADDR_W-1:0];
            default:  addr = ADDR_W'(ir[7:0]);
        endcase
    end

    assign rdata = mem[addr];

    // PC source; relative branch is taken from the already incremented PC
    always_comb begin
        case (PCSrc)
            PCSRC_JMP: pc_next = {PC[15:12], ir[11:0]};
            PCSRC_INC: pc_next = PC + 16'd1;
            PCSRC_REL: pc_next = PC + sext8(ir[7:0]);
            default:   pc_next = PC;
        endcase
    end

    assign pc_load = PCWrite | (Branch & Comparison);

    // Architectural registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC  <= 16'h0000;
            ir  <= 16'h0000;
            mdr <= 16'h0000;
            sp  <= 16'h00FF;
        end else begin
            if (pc_load) PC <= pc_next;
            if (CrtState == S_FETCH) ir <= rdata;
            if (MRead) mdr <= rdata;
            if (SPWrite) sp <= PshPop ? sp + 16'd1 : sp - 16'd1;
        end
    end

    // Synchronous write port; PUSH stores at the pre-decrement SP
    always_ff @(posedge CLK) begin
        if (MWrite) mem[addr] <= MDin ? mdr : PC;
    end

`ifdef PCMC_D2A_COMB_EN
    assign d2a = rdata;
`else
    assign d2a = mdr;
`endif

endmodule

// File: tb/tb_test_pc_mem_control.sv
// Scoreboard bench for test_pc_mem_control: the driver pushes the expected
// state/PC/controls for each cycle, the monitor pops and compares at negedge.
module tb_test_pc_mem_control;

    logic        CLK = 1'b0;
    logic        RST, Comparison;
    logic        PCWrite, MDin, MRead, MWrite, RFRead, RDWrite, SPWrite;
    logic        AWrite, BWrite, ALUInA, ALUOutWrite, Branch, SPRel, PshPop;
    logic [1:0]  PCSrc, MAddr, RFWA, ALUInB;
    logic [2:0]  RFWD;
    logic [3:0]  ALUOp, CrtState;
    logic [15:0] d2a, PC;

    test_pc_mem_control #(.ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .Comparison(Comparison),
        .PCWrite(PCWrite), .MDin(MDin), .MRead(MRead), .MWrite(MWrite),
        .RFRead(RFRead), .RDWrite(RDWrite), .SPWrite(SPWrite),
        .AWrite(AWrite), .BWrite(BWrite), .ALUInA(ALUInA),
        .ALUOutWrite(ALUOutWrite), .Branch(Branch), .SPRel(SPRel),
        .PshPop(PshPop), .PCSrc(PCSrc), .MAddr(MAddr), .RFWA(RFWA),
        .ALUInB(ALUInB), .RFWD(RFWD), .ALUOp(ALUOp), .d2a(d2a), .PC(PC),
        .CrtState(CrtState)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic pcwrite, mdin, mread, mwrite, rfread, rdwrite, spwrite;
        logic awrite, bwrite, aluina, aluoutwrite, branch, sprel, pshpop;
        logic [1:0] pcsrc, maddr, rfwa, aluinb;
        logic [2:0] rfwd;
        logic [3:0] aluop;
    } ctrl_t;

    typedef struct {
        int id; int st; int pc; int alu; int d2a; int sp; int mff;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    event  kick;
    int    tests = 0;
    int    fails = 0;
    int    ncyc  = 0;
    ctrl_t act;

    assign act = {PCWrite, MDin, MRead, MWrite, RFRead, RDWrite, SPWrite,
                  AWrite, BWrite, ALUInA, ALUOutWrite, Branch, SPRel, PshPop,
                  PCSrc, MAddr, RFWA, ALUInB, RFWD, ALUOp};

    // Expected control word per state, written out from the state table
    function automatic ctrl_t exp_ctrl(input int st, input int alu);
        ctrl_t c = '0;
        case (st)
            0:  begin c.pcwrite = 1; c.pcsrc = 2'b01; c.maddr = 2'b01; c.mread = 1; end
            1:  begin c.rfread = 1; c.awrite = 1; c.bwrite = 1; end
            2:  begin c.aluina = 1; c.aluoutwrite = 1; c.aluop = 4'(alu); end
            3:  begin c.rfwd = 3'b011; c.rdwrite = 1; end
            4:  begin c.mdin = 1; c.maddr = 2'b11; c.mwrite = 1; end
            5:  begin c.mread = 1; end
            6:  begin c.rdwrite = 1; end
            7:  begin c.pcwrite = 1; end
            8:  begin c.rfwa = 2'b10; c.rfwd = 3'b100; c.rdwrite = 1; end
            9:  begin c.rfwd = 3'b010; c.rdwrite = 1; end
            10: begin c.aluop = 4'd5; c.aluina = 1; end
            11: begin c.pcsrc = 2'b10; c.branch = 1; end
            12: begin c.rfwd = 3'b001; c.rfwa = 2'b01; c.rdwrite = 1; c.pcwrite = 1; end
            13: begin c.maddr = 2'b10; c.spwrite = 1; c.mdin = 1; c.mwrite = 1; end
            14: begin c.pshpop = 1; c.maddr = 2'b01; c.spwrite = 1; c.mread = 1; end
            15: begin c.rdwrite = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s cyc%0d: got %h want %h", nm, id, a, x);
        end
    endtask

    // Monitor: compare every queued expectation when outputs are stable
    always begin
        @(negedge CLK or kick);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state", e.id, 32'(CrtState), 32'(e.st));
            chk("pc",    e.id, 32'(PC),       32'(e.pc));
            chk("ctrl",  e.id, 32'(act),      32'(exp_ctrl(e.st, e.alu)));
            if (e.d2a >= 0) chk("d2a", e.id, 32'(d2a), 32'(e.d2a));
            if (e.sp  >= 0) chk("sp",  e.id, 32'(dut.sp), 32'(e.sp));
            if (e.mff >= 0) chk("mem_ff", e.id, 32'(dut.mem[255]), 32'(e.mff));
        end
    end

    task automatic push(input int st, input int pc, input int alu, input int d2a_x,
                        input int sp_x, input int mff);
        exp_t x;
        x.id = ncyc; x.st = st; x.pc = pc; x.alu = alu;
        x.d2a = d2a_x; x.sp = sp_x; x.mff = mff;
        ncyc++;
        sb.push_back(x);
    endtask

    // One clocked cycle: expectation for the state after the next rising edge
    task automatic cyc(input int st, input int pc, input int alu, input int d2a_x,
                       input int sp_x, input int mff);
        push(st, pc, alu, d2a_x, sp_x, mff);
        @(negedge CLK);
        #1;
    endtask

    // Immediate check with no clock edge (used while reset is asserted)
    task automatic now(input int st, input int pc, input int d2a_x, input int sp_x);
        push(st, pc, 0, d2a_x, sp_x, -1);
        ->kick;
        #1;
    endtask

    task automatic release_rst();
        @(negedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Program words 0..6: RTYPE, SW, LW, J, LI, MOV, up to BEQ1
    task automatic to_beq();
        cyc(1, 1, 0, 'h0003, -1, -1);
        cyc(2, 1, 3, -1, -1, -1);
        cyc(3, 1, 0, -1, -1, -1);
        cyc(0, 1, 0, -1, -1, -1);
        cyc(1, 2, 0, 'h1080, -1, -1);
        cyc(4, 2, 0, -1, -1, -1);
        cyc(0, 2, 0, -1, -1, -1);
        cyc(1, 3, 0, 'h2080, -1, -1);
        cyc(5, 3, 0, -1, -1, -1);
        cyc(6, 3, 0, 'h1080, -1, -1);
        cyc(0, 3, 0, -1, -1, -1);
        cyc(1, 4, 0, 'h3004, -1, -1);
        cyc(7, 4, 0, -1, -1, -1);
        cyc(0, 4, 0, -1, -1, -1);
        cyc(1, 5, 0, 'h4012, -1, -1);
        cyc(8, 5, 0, -1, -1, -1);
        cyc(0, 5, 0, -1, -1, -1);
        cyc(1, 6, 0, 'h5000, -1, -1);
        cyc(9, 6, 0, -1, -1, -1);
        cyc(0, 6, 0, -1, -1, -1);
        cyc(1, 7, 0, 'h6002, -1, -1);
        cyc(10, 7, 0, -1, -1, -1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        Comparison = 1'b0;
        #1;
        now(0, 0, 0, 'hFF);
        release_rst();

        // Run 1: branch not taken, then JAL, PUSH, POP
        to_beq();
        Comparison = 1'b1;
        cyc(11, 7, 0, -1, -1, -1);
        Comparison = 1'b0;
        cyc(0, 7, 0, -1, -1, -1);
        cyc(1, 8, 0, 'h7009, -1, -1);
        cyc(12, 8, 0, -1, -1, -1);
        cyc(0, 9, 0, -1, -1, -1);
        cyc(1, 10, 0, 'h8000, 'hFF, -1);
        cyc(13, 10, 0, -1, 'hFF, 0);
        cyc(0, 10, 0, -1, 'hFE, 'h8000);
        cyc(1, 11, 0, 'h9000, 'hFE, -1);
        cyc(14, 11, 0, -1, 'hFE, -1);
        cyc(15, 11, 0, 'h0000, 'hFF, -1);
        cyc(0, 11, 0, -1, -1, -1);
        cyc(1, 12, 0, 'h0000, -1, -1);
        cyc(2, 12, 0, -1, -1, -1);

        // Run 2: reset mid-RTYPE, branch taken to word 9
        RST = 1'b1;
        #1;
        now(0, 0, 0, 'hFF);
        release_rst();
        to_beq();
        Comparison = 1'b1;
        cyc(11, 7, 0, -1, -1, -1);
        cyc(0, 9, 0, -1, -1, -1);
        Comparison = 1'b0;
        cyc(1, 10, 0, 'h8000, -1, -1);
        cyc(13, 10, 0, -1, 'hFF, -1);
        cyc(0, 10, 0, -1, 'hFE, -1);

        // Run 3: asynchronous reset while in LW1
        RST = 1'b1;
        #1;
        now(0, 0, 0, 'hFF);
        release_rst();
        cyc(1, 1, 0, 'h0003, -1, -1);
        cyc(2, 1, 3, -1, -1, -1);
        cyc(3, 1, 0, -1, -1, -1);
        cyc(0, 1, 0, -1, -1, -1);
        cyc(1, 2, 0, 'h1080, -1, -1);
        cyc(4, 2, 0, -1, -1, -1);
        cyc(0, 2, 0, -1, -1, -1);
        cyc(1, 3, 0, 'h2080, -1, -1);
        cyc(5, 3, 0, -1, -1, -1);
        RST = 1'b1;
        #1;
        now(0, 0, 0, 'hFF);

        #2;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
